// File: rtl/alu_branch_unit.sv
// alu_branch_unit: resolves RV32I conditional branches and JAL/JALR, produces
// the link value and a misaligned-target flag, and presents the result through
// a one-stage registered valid/ready pipeline with flush and branch counters.
module alu_branch_unit #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16,
    parameter int ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_kind,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_value,
    input  logic [XLEN-1:0]  rs2_value,
    input  logic [XLEN-1:0]  immediate,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  next_pc,
    output logic             taken,
    output logic [XLEN-1:0]  link_value,
    output logic             misaligned,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        OP_BRANCH = 2'd0,
        OP_JAL    = 2'd1,
        OP_JALR   = 2'd2,
        OP_RSVD   = 2'd3
    } op_kind_e;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    op_kind_e        kind;
    logic            cond_true;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] branch_sum;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            taken_d;
    logic            misaligned_d;
    logic [XLEN-1:0] next_pc_d;
    logic            is_branch_q;
    logic            accept;
    logic            deliver;

    assign kind     = op_kind_e'(op_kind);
    // A held result that is leaving this cycle frees the stage, so no bubble.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    // A flushed entry is dropped, not delivered, so it never reaches the counters.
    assign deliver  = out_valid && out_ready && !flush;

    // Evaluate the conditional-branch comparison selected by funct3.
    always_comb begin
        // NOTE: default first so every path assigns cond_true and no latch is inferred.
        cond_true = 1'b0;
        case (funct3)
            F3_BEQ:  cond_true = (rs1_value == rs2_value);
            F3_BNE:  cond_true = (rs1_value != rs2_value);
            F3_BLT:  cond_true = ($signed(rs1_value) <  $signed(rs2_value));
            F3_BGE:  cond_true = ($signed(rs1_value) >= $signed(rs2_value));
            F3_BLTU: cond_true = (rs1_value <  rs2_value);
            F3_BGEU: cond_true = (rs1_value >= rs2_value);
            default: cond_true = 1'b0;
        endcase
    end

    // Compute target, taken decision, next PC and alignment flag.
    always_comb begin
        seq_pc     = pc + XLEN'(4);
        branch_sum = pc + immediate;
        jalr_sum   = rs1_value + immediate;
        target     = branch_sum;
        taken_d    = 1'b0;
        case (kind)
            OP_BRANCH: taken_d = cond_true;
            OP_JAL:    taken_d = 1'b1;
            OP_JALR: begin
                taken_d = 1'b1;
                target  = jalr_sum & ~XLEN'(1);
            end
            default:   taken_d = 1'b0;
        endcase
        next_pc_d    = taken_d ? target : seq_pc;
        // The raw target is still forwarded; the consumer raises the trap.
        misaligned_d = taken_d && (target[ALIGN_BITS-1:0] != '0);
    end

    // Result register with handshake, flush and reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: datapath registers are reset too because their zero values are visible outputs.
            out_valid   <= 1'b0;
            next_pc     <= '0;
            taken       <= 1'b0;
            link_value  <= '0;
            misaligned  <= 1'b0;
            is_branch_q <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            next_pc     <= next_pc_d;
            taken       <= taken_d;
            link_value  <= seq_pc;
            misaligned  <= misaligned_d;
            is_branch_q <= (kind == OP_BRANCH);
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    // Performance counters advance when a conditional branch is delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (deliver && is_branch_q) begin
            branch_count <= branch_count + CNT_W'(1);
            if (taken) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

endmodule
